mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares a single unified `mem` instance between the fetch port (IF stage) and the data port (MEM stage) of the 5-stage pipeline, replacing the separate IM/DM memories. It arbitrates each cycle's request, tracks outstanding load tags, and routes tagged read data back to the port that issued the load. A starvation counter keeps instruction fetch from being locked out by back-to-back data traffic.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: consecutive cycles IF may lose to DM before IF is forced priority (1..7).
- `NTAGS`, 16: tag table depth; tag 0 means "no tag".

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `if_addr`  in  32  fetch address
- `if_command`  in  2  BUS_NONE or BUS_LOAD; BUS_STORE is treated as BUS_NONE
- `if_grant`  out  1  fetch request accepted by memory this cycle
- `if_rdata`  out  32  returned instruction word
- `if_rvalid`  out  1  `if_rdata` valid this cycle
- `dm_addr`  in  32  data address
- `dm_wdata`  in  32  store data
- `dm_command`  in  2  BUS_NONE / BUS_LOAD / BUS_STORE
- `dm_grant`  out  1  data request accepted by memory this cycle
- `dm_rdata`  out  32  returned load data
- `dm_rvalid`  out  1  `dm_rdata` valid this cycle
- `proc2mem_addr`  out  32  to mem
- `proc2mem_data`  out  32  to mem
- `proc2mem_command`  out  2  to mem
- `mem2proc_response`  in  4  nonzero = accepted, value is the tag
- `mem2proc_data`  in  32  returned data
- `mem2proc_tag`  in  4  nonzero = data for that tag this cycle
- `tag_err`  out  1  sticky: tag returned that was not outstanding

## Operation
- Arbitration, combinational each cycle: DM wins if `dm_command != BUS_NONE`, unless `starve_cnt == STARVE_LIMIT` and IF is requesting, in which case IF wins. Only the winner drives `proc2mem_*`; with no requester, command = BUS_NONE, addr/data = 0.
- `x_grant` = port is the winner and `mem2proc_response != 0`. A winner seeing response 0 (memory busy) is not granted and must hold its request; the arbiter does not latch requests.
- Starvation counter (3-bit): +1 in each cycle IF requests and DM wins, saturating at STARVE_LIMIT; cleared when `if_grant`; unchanged otherwise, including cycles where IF wins but memory is busy.
- Tag table: per tag, `valid` and `owner` (IF/DM). A granted BUS_LOAD writes `table[response] = {1, owner}`. Granted stores allocate nothing and are complete at grant.
- Return: if `mem2proc_tag != 0` and `table[tag].valid`, assert `if_rvalid` or `dm_rvalid` per owner, drive `mem2proc_data` on both `*_rdata`, and clear the entry next edge. If the entry is not valid, drop the data and set `tag_err`.
- Same tag returned and reallocated in one cycle: the allocation wins; the entry stays valid with the new owner.
- Reset: table cleared, `starve_cnt = 0`, `tag_err = 0`. All outputs are combinational from the table and inputs, so under `rst` every grant/rvalid is 0 and `proc2mem_command = BUS_NONE`. Loads in flight across reset are orphaned; their returns set `tag_err` only if they arrive after reset deasserts.

## Timing
- Request to grant: 0 cycles (same cycle as `mem2proc_response`).
- Tag return to `*_rvalid`: 0 cycles. The load-to-data latency is the memory's.
- State updates (table, counter, `tag_err`) occur on the `clk` edge; an entry allocated in cycle N can be matched by a return in cycle N+1 at the earliest.
- With continuous DM traffic and a waiting IF, IF is granted no later than cycle STARVE_LIMIT+1, provided memory is not busy.

## Structure
- BUS_NONE/BUS_LOAD/BUS_STORE and the 4-bit tag width come from the shared `sys_defs` definitions; add an owner enum `{OWN_IF, OWN_DM}` there.
- One sub-module, `mem_tag_table`: NTAGS×{valid, owner} register file with one allocate port and one lookup/clear port, implementing the allocate-wins rule.

## Test plan
- Only IF loads addr 0x40, response 3; tag 3 returns with 0x00000013 -> `if_grant=1` that cycle; later `if_rvalid=1`, `if_rdata=0x13`, `dm_rvalid=0`.
- IF and DM load together, response 5 -> `dm_grant=1`, `if_grant=0`; tag 5 returns -> `dm_rvalid=1` only.
- DM requests every cycle, IF waiting, STARVE_LIMIT=4, response always nonzero -> DM granted cycles 1-4, IF granted cycle 5, counter 0 after.
- DM store to 0x100, data 0xDEADBEEF, response 7 -> `dm_grant=1`; `proc2mem_command=BUS_STORE`; no table entry; a later tag-7 return sets `tag_err`.
- Tag 2 returns to IF while a new DM load is granted with response 2 -> `if_rvalid=1` this cycle; next return of tag 2 gives `dm_rvalid=1`.
- Mem busy (response 0) for 3 cycles on an IF-only request -> `if_grant=0` each cycle, counter stays 0; reset mid-load -> the outstanding return after reset sets `tag_err`.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared system definitions for the unified memory arbiter: bus commands,
// tag width and load-owner encoding.
package mem_arbiter_pkg;

   localparam int TAG_W = 4;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } bus_command_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   // Tag 0 is reserved to mean "no tag".
   function automatic logic tag_live(input logic [TAG_W-1:0] tag);
      return (tag != {TAG_W{1'b0}});
   endfunction

endpackage

// File: rtl/mem_tag_table.sv
// Outstanding-load table: one valid/owner pair per memory tag, with one
// allocate port and one lookup/clear port; allocation beats a same-tag clear.
module mem_tag_table
   import mem_arbiter_pkg::*;
#(
   parameter int NTAGS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_en_i,
   input  logic [TAG_W-1:0] alloc_tag_i,
   input  owner_t           alloc_owner_i,
   input  logic [TAG_W-1:0] lkup_tag_i,
   input  logic             clear_en_i,
   output logic             hit_o,
   output owner_t           hit_owner_o
);

   logic [NTAGS-1:0] valid_q, valid_d;
   logic [NTAGS-1:0] owner_q, owner_d;
   logic [NTAGS-1:0] match;

   // Lookup: entry 0 never matches, so a zero tag is never a hit.
   always_comb begin
      match = {NTAGS{1'b0}};
      for (int i = 1; i < NTAGS; i++) begin
         match[i] = valid_q[i] && (lkup_tag_i == TAG_W'(i));
      end
      hit_o       = |match;
      hit_owner_o = owner_t'(|(match & owner_q));
   end

   // Next state: allocate has priority over clear for the same entry.
   always_comb begin
      valid_d = valid_q;
      owner_d = owner_q;
      for (int i = 0; i < NTAGS; i++) begin
         if (alloc_en_i && (alloc_tag_i == TAG_W'(i))) begin
            valid_d[i] = 1'b1;
            owner_d[i] = alloc_owner_i;
         end else if (clear_en_i && (lkup_tag_i == TAG_W'(i))) begin
            valid_d[i] = 1'b0;
            owner_d[i] = owner_q[i];
         end else begin
            valid_d[i] = valid_q[i];
            owner_d[i] = owner_q[i];
         end
      end
   end

   // Table registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= {NTAGS{1'b0}};
         owner_q <= {NTAGS{1'b0}};
      end else begin
         valid_q <= valid_d;
         owner_q <= owner_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one tagged memory, routes returned
// load data to the issuing port and keeps fetch from starving behind data.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int NTAGS        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      if_addr,
   input  logic [1:0]       if_command,
   output logic             if_grant,
   output logic [31:0]      if_rdata,
   output logic             if_rvalid,
   input  logic [31:0]      dm_addr,
   input  logic [31:0]      dm_wdata,
   input  logic [1:0]       dm_command,
   output logic             dm_grant,
   output logic [31:0]      dm_rdata,
   output logic             dm_rvalid,
   output logic [31:0]      proc2mem_addr,
   output logic [31:0]      proc2mem_data,
   output logic [1:0]       proc2mem_command,
   input  logic [TAG_W-1:0] mem2proc_response,
   input  logic [31:0]      mem2proc_data,
   input  logic [TAG_W-1:0] mem2proc_tag,
   output logic             tag_err
);

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   logic [2:0] starve_q, starve_d;
   logic       tag_err_q, tag_err_d;
   logic       if_req, dm_req, if_win, dm_win, resp_ok;
   logic       alloc_en, ret_hit;
   owner_t     alloc_owner, hit_owner;
   logic       tbl_hit;

   // Arbitration and memory-side drive; everything is quiet during reset.
   always_comb begin
      if_req  = (if_command == BUS_LOAD);
      dm_req  = (dm_command != BUS_NONE);
      resp_ok = tag_live(mem2proc_response);
      dm_win  = dm_req && !(if_req && (starve_q == LIMIT)) && !rst;
      if_win  = if_req && !dm_win && !rst;

      proc2mem_addr    = 32'h0000_0000;
      proc2mem_data    = 32'h0000_0000;
      proc2mem_command = BUS_NONE;
      if (dm_win) begin
         proc2mem_addr    = dm_addr;
         proc2mem_data    = dm_wdata;
         proc2mem_command = dm_command;
      end else if (if_win) begin
         proc2mem_addr    = if_addr;
         proc2mem_data    = 32'h0000_0000;
         proc2mem_command = BUS_LOAD;
      end else begin
         proc2mem_command = BUS_NONE;
      end

      if_grant = if_win && resp_ok;
      dm_grant = dm_win && resp_ok;

      // Stores complete at grant; only loads occupy a tag.
      alloc_en    = if_grant || (dm_grant && (dm_command == BUS_LOAD));
      alloc_owner = if_grant ? OWN_IF : OWN_DM;
   end

   mem_tag_table #(
      .NTAGS(NTAGS)
   ) u_tag_table (
      .clk           (clk),
      .rst           (rst),
      .alloc_en_i    (alloc_en),
      .alloc_tag_i   (mem2proc_response),
      .alloc_owner_i (alloc_owner),
      .lkup_tag_i    (mem2proc_tag),
      .clear_en_i    (ret_hit),
      .hit_o         (tbl_hit),
      .hit_owner_o   (hit_owner)
   );

   // Return routing, starvation count and orphan-tag detection.
   always_comb begin
      ret_hit   = tbl_hit && !rst;
      if_rvalid = ret_hit && (hit_owner == OWN_IF);
      dm_rvalid = ret_hit && (hit_owner == OWN_DM);
      if_rdata  = mem2proc_data;
      dm_rdata  = mem2proc_data;

      starve_d = starve_q;
      if (if_grant) begin
         starve_d = 3'd0;
      end else if (if_req && dm_win && (starve_q != LIMIT)) begin
         starve_d = starve_q + 3'd1;
      end else begin
         starve_d = starve_q;
      end

      tag_err_d = tag_err_q;
      if (tag_live(mem2proc_tag) && !tbl_hit) begin
         tag_err_d = 1'b1;
      end else begin
         tag_err_d = tag_err_q;
      end
   end

   // Arbiter state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q  <= 3'd0;
         tag_err_q <= 1'b0;
      end else begin
         starve_q  <= starve_d;
         tag_err_q <= tag_err_d;
      end
   end

   assign tag_err = tag_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: stimulus pushes expected returns,
// a negedge monitor pops them whenever the DUT raises an rvalid.
module tb_mem_arbiter;

   localparam logic [1:0] NONE  = 2'h0;
   localparam logic [1:0] LOAD  = 2'h1;
   localparam logic [1:0] STORE = 2'h2;

   typedef struct {
      logic        is_dm;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem2proc_data;
   logic [1:0]  if_command, dm_command;
   logic [3:0]  mem2proc_response, mem2proc_tag;
   logic        if_grant, if_rvalid, dm_grant, dm_rvalid, tag_err;
   logic [31:0] if_rdata, dm_rdata, proc2mem_addr, proc2mem_data;
   logic [1:0]  proc2mem_command;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_LIMIT(4), .NTAGS(16)) dut (
      .clk(clk), .rst(rst),
      .if_addr(if_addr), .if_command(if_command), .if_grant(if_grant),
      .if_rdata(if_rdata), .if_rvalid(if_rvalid),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_command(dm_command),
      .dm_grant(dm_grant), .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid),
      .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
      .proc2mem_command(proc2mem_command),
      .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
      .mem2proc_tag(mem2proc_tag), .tag_err(tag_err)
   );

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk32(name, {31'd0, act}, {31'd0, exp});
   endtask

   task automatic idle();
      if_addr = 32'h0; if_command = NONE;
      dm_addr = 32'h0; dm_wdata = 32'h0; dm_command = NONE;
      mem2proc_response = 4'h0; mem2proc_data = 32'h0; mem2proc_tag = 4'h0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      idle();
   endtask

   // Scoreboard monitor: every rvalid must match the oldest expected return.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (if_rvalid || dm_rvalid)) begin
         if (exp_q.size() == 0) begin
            chk1("unexpected_rvalid", if_rvalid | dm_rvalid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            chk1("if_rvalid", if_rvalid, !e.is_dm);
            chk1("dm_rvalid", dm_rvalid, e.is_dm);
            chk32(e.is_dm ? "dm_rdata" : "if_rdata", e.is_dm ? dm_rdata : if_rdata, e.data);
         end
      end
   end

   initial begin
      idle();
      rst = 1'b1;
      // Reset with a live IF request and accepting memory: nothing may issue.
      if_command = LOAD; if_addr = 32'h40; mem2proc_response = 4'h3;
      @(negedge clk);
      chk1("rst_if_grant", if_grant, 1'b0);
      chk1("rst_dm_grant", dm_grant, 1'b0);
      chk32("rst_cmd", {30'd0, proc2mem_command}, {30'd0, NONE});
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk1("rst_tag_err", tag_err, 1'b0);

      // 1: IF-only load, tag 3 returns 0x13.
      next_cycle();
      if_command = LOAD; if_addr = 32'h40; mem2proc_response = 4'h3;
      exp_q.push_back('{1'b0, 32'h0000_0013});
      @(negedge clk);
      chk1("t1_if_grant", if_grant, 1'b1);
      chk1("t1_dm_grant", dm_grant, 1'b0);
      chk32("t1_addr", proc2mem_addr, 32'h40);
      chk32("t1_cmd", {30'd0, proc2mem_command}, {30'd0, LOAD});
      next_cycle();
      next_cycle();
      mem2proc_tag = 4'h3; mem2proc_data = 32'h0000_0013;
      @(negedge clk);

      // 2: IF and DM together, DM wins; tag 5 returns to DM; replaying it is an orphan.
      next_cycle();
      if_command = LOAD; if_addr = 32'h44;
      dm_command = LOAD; dm_addr = 32'h200; mem2proc_response = 4'h5;
      exp_q.push_back('{1'b1, 32'hA5A5_0005});
      @(negedge clk);
      chk1("t2_dm_grant", dm_grant, 1'b1);
      chk1("t2_if_grant", if_grant, 1'b0);
      chk32("t2_addr", proc2mem_addr, 32'h200);
      next_cycle();
      mem2proc_tag = 4'h5; mem2proc_data = 32'hA5A5_0005;
      @(negedge clk);
      next_cycle();
      chk1("t2_err_clean", tag_err, 1'b0);
      mem2proc_tag = 4'h5; mem2proc_data = 32'h0BAD_0005;
      @(negedge clk);
      chk1("t2_replay_if_rv", if_rvalid, 1'b0);
      chk1("t2_replay_dm_rv", dm_rvalid, 1'b0);
      next_cycle();
      @(negedge clk);
      chk1("t2_replay_err", tag_err, 1'b1);

      // 3: starvation with counter starting at 0.
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         if_command = LOAD; if_addr = 32'h80;
         dm_command = STORE; dm_addr = 32'h500 + 32'(c); dm_wdata = 32'(c);
         mem2proc_response = 4'h1;
         if (c == 5) exp_q.push_back('{1'b0, 32'h1111_0001});
         @(negedge clk);
         chk1($sformatf("t3_if_grant_c%0d", c), if_grant, (c == 5));
         chk1($sformatf("t3_dm_grant_c%0d", c), dm_grant, (c != 5));
         if (c == 5) chk32("t3_if_addr", proc2mem_addr, 32'h80);
         next_cycle();
      end
      mem2proc_tag = 4'h1; mem2proc_data = 32'h1111_0001;
      @(negedge clk);

      // 4: DM store allocates nothing; a tag-7 return is an orphan.
      next_cycle();
      dm_command = STORE; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; mem2proc_response = 4'h7;
      @(negedge clk);
      chk1("t4_dm_grant", dm_grant, 1'b1);
      chk32("t4_cmd", {30'd0, proc2mem_command}, {30'd0, STORE});
      chk32("t4_addr", proc2mem_addr, 32'h100);
      chk32("t4_data", proc2mem_data, 32'hDEAD_BEEF);
      chk1("t4_err_before", tag_err, 1'b0);
      next_cycle();
      mem2proc_tag = 4'h7; mem2proc_data = 32'h0000_0777;
      @(negedge clk);
      chk1("t4_ret_if_rv", if_rvalid, 1'b0);
      chk1("t4_ret_dm_rv", dm_rvalid, 1'b0);
      next_cycle();
      @(negedge clk);
      chk1("t4_tag_err", tag_err, 1'b1);
      next_cycle();
      rst = 1'b1;
      dm_command = STORE; mem2proc_response = 4'h2;
      @(negedge clk);
      chk32("t4_rst_cmd", {30'd0, proc2mem_command}, {30'd0, NONE});
      chk1("t4_rst_dm_grant", dm_grant, 1'b0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk1("t4_err_cleared", tag_err, 1'b0);

      // 5: tag 2 returns to IF while being reallocated to DM.
      next_cycle();
      if_command = LOAD; if_addr = 32'h60; mem2proc_response = 4'h2;
      exp_q.push_back('{1'b0, 32'h2222_0002});
      @(negedge clk);
      chk1("t5_if_grant", if_grant, 1'b1);
      next_cycle();
      mem2proc_tag = 4'h2; mem2proc_data = 32'h2222_0002;
      dm_command = LOAD; dm_addr = 32'h300; mem2proc_response = 4'h2;
      exp_q.push_back('{1'b1, 32'h3333_0002});
      @(negedge clk);
      chk1("t5_dm_grant", dm_grant, 1'b1);
      next_cycle();
      mem2proc_tag = 4'h2; mem2proc_data = 32'h3333_0002;
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      chk1("t5_no_err", tag_err, 1'b0);

      // 6: busy memory holds the counter; then starvation still needs 4 losses.
      for (int c = 1; c <= 3; c++) begin
         next_cycle();
         if_command = LOAD; if_addr = 32'h90; mem2proc_response = 4'h0;
         @(negedge clk);
         chk1($sformatf("t6_busy_grant_c%0d", c), if_grant, 1'b0);
         chk32($sformatf("t6_busy_cmd_c%0d", c), {30'd0, proc2mem_command}, {30'd0, LOAD});
      end
      for (int c = 1; c <= 5; c++) begin
         next_cycle();
         if_command = LOAD; if_addr = 32'h90;
         dm_command = STORE; dm_addr = 32'h600; mem2proc_response = 4'h4;
         @(negedge clk);
         chk1($sformatf("t6_if_grant_c%0d", c), if_grant, (c == 5));
      end
      // Tag 4 is now outstanding for IF; reset orphans it.
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      mem2proc_tag = 4'h4; mem2proc_data = 32'h4444_0004;
      @(negedge clk);
      chk1("t6_orphan_if_rv", if_rvalid, 1'b0);
      chk1("t6_err_before", tag_err, 1'b0);
      next_cycle();
      @(negedge clk);
      chk1("t6_orphan_err", tag_err, 1'b1);

      chk32("scoreboard_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
